// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush/halt control for tinyriscv.
// Optional stall counter: define PIPE_HOLD_CTRL_PERF_CNT_EN.
module pipe_hold_ctrl #(
  parameter int NUM_REQ   = 4,
  parameter int STAGES    = 4,
  parameter int ADDR_W    = 32,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 32,
  localparam int LVL_W    = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     jump_req_i,
  input  logic [ADDR_W-1:0]        jump_addr_i,
  input  logic [NUM_REQ-1:0]       hold_req_i,
  input  logic [NUM_REQ*LVL_W-1:0] hold_lvl_i,
  input  logic                     halt_req_i,
  input  logic                     drain_busy_i,
  output logic                     jump_flag_o,
  output logic [ADDR_W-1:0]        jump_addr_o,
  output logic [STAGES-1:0]        hold_o,
  output logic [STAGES-1:0]        flush_o,
  output logic                     halted_o,
  output logic [CNT_W-1:0]         stall_cnt_o
);

  localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {
    RUN, FLUSH, DRAIN, HALTED
  } state_e;

  state_e            state_q, state_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic              halted_q;
  logic [STAGES-1:0] hold_raw;
  logic [STAGES-1:0] fmask;
  logic [STAGES-1:0] dmask;
  logic [LVL_W-1:0]  lvl_max;
  logic              any_req;

  // Highest clamped hold level among active requesters.
  always_comb begin
    logic [LVL_W-1:0] s;
    s       = '0;
    lvl_max = '0;
    any_req = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (hold_req_i[r]) begin
        s = hold_lvl_i[r*LVL_W +: LVL_W];
        if (int'(s) > STAGES - 1)
          s = LVL_W'(STAGES - 1);
        if (s > lvl_max)
          lvl_max = s;
        any_req = 1'b1;
      end
    end
  end

  // Thermometer hold mask plus fixed flush/drain masks.
  always_comb begin
    hold_raw = '0;
    fmask    = '0;
    dmask    = '0;
    for (int k = 0; k < STAGES; k++) begin
      hold_raw[k] = any_req && (int'(lvl_max) >= k);
      fmask[k]    = (k < STAGES - 1);
      dmask[k]    = (k == 1);
    end
  end

  // Zero-latency redirect, hold and flush outputs.
  always_comb begin
    jump_flag_o = 1'b0;
    flush_o     = '0;
    hold_o      = '0;
    if (!rst) begin
      unique case (state_q)
        RUN, FLUSH: begin
          jump_flag_o = jump_req_i;
          if (jump_req_i || state_q == FLUSH)
            flush_o = fmask;
          hold_o = hold_raw & ~flush_o;
        end
        DRAIN: begin
          jump_flag_o = jump_req_i;
          flush_o = dmask | (jump_req_i ? fmask : '0);
          hold_o = (hold_raw | STAGES'(1)) & ~flush_o;
        end
        HALTED: begin
          hold_o = '1;
        end
        default: ;
      endcase
    end
    jump_addr_o = jump_flag_o ? jump_addr_i : '0;
  end

  // Next state and flush window counter.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      RUN: begin
        if (jump_req_i) begin
          if (FLUSH_CYC > 1) begin
            fcnt_d  = FC_LOAD;
            state_d = FLUSH;
          end else if (halt_req_i) begin
            state_d = DRAIN;
          end
        end else if (halt_req_i) begin
          state_d = DRAIN;
        end
      end
      FLUSH: begin
        if (jump_req_i) begin
          fcnt_d = FC_LOAD;
        end else if (fcnt_q <= FC_W'(1)) begin
          fcnt_d  = '0;
          state_d = halt_req_i ? DRAIN : RUN;
        end else begin
          fcnt_d = fcnt_q - FC_W'(1);
        end
      end
      DRAIN: begin
        if (!halt_req_i)
          state_d = RUN;
        else if (!jump_req_i && !drain_busy_i)
          state_d = HALTED;
      end
      HALTED: begin
        if (!halt_req_i)
          state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // State, flush counter and halted status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      fcnt_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      halted_q <= (state_d == HALTED);
    end
  end

  assign halted_o = halted_q;

`ifdef PIPE_HOLD_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_inc;

  assign cnt_inc = (state_q != HALTED) && (hold_o[0] || flush_o[0])
                && (cnt_q != '1);
  assign cnt_d   = cnt_inc ? cnt_q + CNT_W'(1) : cnt_q;

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign stall_cnt_o = cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
